// File: rtl/victim_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : victim_write_buffer
// Purpose  : Write-back buffer between the data cache dirty-victim path and
//            the AXI write channels. Evicted 128-bit blocks are accepted in a
//            single cycle, queued in a DEPTH-entry FIFO and drained one at a
//            time as 4-beat INCR bursts of 32-bit words. A combinational
//            address lookup lets the refill path forward from entries that
//            have not yet reached memory.
// Ports    : clk, rstn                 - clock, asynchronous active-low reset
//            push_valid/ready/addr/block - victim block intake
//            lookup_addr/hit/block     - refill-path forwarding lookup
//            empty                     - no entries held and drain idle
//            aw* / w* / b*             - AXI write address, data, response
// Revision : 1.0 - initial release
// ============================================================================
module victim_write_buffer #(
  parameter int         DEPTH = 4,
  parameter logic [3:0] ID    = 4'h1
) (
  input  logic         clk,
  input  logic         rstn,
  // victim intake
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [31:0]  push_addr,
  input  logic [127:0] push_block,
  // refill lookup
  input  logic [31:0]  lookup_addr,
  output logic         lookup_hit,
  output logic [127:0] lookup_block,
  output logic         empty,
  // AXI write address channel
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data channel
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response channel
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0] c_ptr_one  = (PTR_W+1)'(1);
  localparam logic [7:0]     c_awlen    = 8'd3;     // 4 beats
  localparam logic [2:0]     c_awsize   = 3'd2;     // 4 bytes per beat
  localparam logic [1:0]     c_awburst  = 2'b01;    // INCR
  localparam logic [3:0]     c_wstrb    = 4'hF;
  localparam logic [1:0]     c_last_beat = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [27:0]      r_addr  [DEPTH];
  logic [127:0]     r_block [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W:0]   r_head;
  logic [PTR_W:0]   r_tail;

  state_t           r_state;
  logic [1:0]       r_beat;
  logic             r_awvalid;
  logic [31:0]      r_awaddr;
  logic             r_wvalid;
  logic [31:0]      r_wdata;
  logic             r_wlast;
  logic             r_bready;

  logic [PTR_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_tail_idx;
  logic [PTR_W:0]   w_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [127:0]     w_head_block;
  logic [1:0]       w_next_beat;
  logic [PTR_W-1:0] w_lk_idx;
  logic             w_hit;
  logic [127:0]     w_hit_block;
  logic             w_unused;

  assign w_head_idx   = r_head[PTR_W-1:0];
  assign w_tail_idx   = r_tail[PTR_W-1:0];
  assign w_count      = r_tail - r_head;
  // Full when the slot indices meet but the wrap bits differ.
  assign w_full       = (r_head[PTR_W] != r_tail[PTR_W]) && (w_head_idx == w_tail_idx);
  // Based on registered state only: a pop this cycle does not reopen a full buffer.
  assign w_push       = push_valid && !w_full;
  assign w_pop        = (r_state == S_B) && bvalid;
  assign w_head_block = r_block[w_head_idx];
  assign w_next_beat  = r_beat + 2'd1;

  // Response id/status are not acted upon; the entry retires regardless.
  assign w_unused = ^{bid, bresp, push_addr[3:0], lookup_addr[3:0]};

  // Payload storage needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[w_tail_idx]  <= push_addr[31:4];
      r_block[w_tail_idx] <= push_block;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_tail              <= r_tail + c_ptr_one;
      end
      if (w_pop) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + c_ptr_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lookup: scan oldest to youngest so the youngest match wins. The draining
  // head entry stays visible until its write response retires it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit       = 1'b0;
    w_hit_block = '0;
    w_lk_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_lk_idx = w_head_idx + PTR_W'(i);
      if (r_valid[w_lk_idx] && (r_addr[w_lk_idx] == lookup_addr[31:4])) begin
        w_hit       = 1'b1;
        w_hit_block = r_block[w_lk_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM: all AXI outputs are registered, so ready never feeds valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_beat    <= 2'd0;
      r_awvalid <= 1'b0;
      r_awaddr  <= 32'd0;
      r_wvalid  <= 1'b0;
      r_wdata   <= 32'd0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_count != '0) begin
            r_state   <= S_AW;
            r_awvalid <= 1'b1;
            r_awaddr  <= {r_addr[w_head_idx], 4'h0};
          end
        end
        S_AW: begin
          if (awready) begin
            r_state   <= S_W;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_beat    <= 2'd0;
            r_wdata   <= w_head_block[31:0];
            r_wlast   <= 1'b0;
          end
        end
        S_W: begin
          if (wready) begin
            if (r_beat == c_last_beat) begin
              r_state  <= S_B;
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
            end else begin
              r_beat  <= w_next_beat;
              r_wdata <= w_head_block[{w_next_beat, 5'd0} +: 32];
              r_wlast <= (w_next_beat == c_last_beat);
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            r_state  <= S_IDLE;
            r_bready <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign push_ready   = !w_full;
  assign lookup_hit   = w_hit;
  assign lookup_block = w_hit_block;
  assign empty        = (w_count == '0) && (r_state == S_IDLE);

  assign awid    = ID;
  assign awaddr  = r_awaddr;
  assign awlen   = c_awlen;
  assign awsize  = c_awsize;
  assign awburst = c_awburst;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;
  assign awvalid = r_awvalid;

  assign wid    = ID;
  assign wdata  = r_wdata;
  assign wstrb  = c_wstrb;
  assign wlast  = r_wlast;
  assign wvalid = r_wvalid;

  assign bready = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_victim_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_victim_write_buffer
// Purpose  : Self-checking bench for victim_write_buffer. A queue of pending
//            blocks models the buffer; the bench acts as the AXI slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_victim_write_buffer;

  localparam int         DEPTH = 4;
  localparam logic [3:0] ID    = 4'h1;

  logic         clk = 1'b0;
  logic         rstn;
  logic         push_valid;
  logic         push_ready;
  logic [31:0]  push_addr;
  logic [127:0] push_block;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_block;
  logic         empty;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [1:0]   awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  victim_write_buffer #(.DEPTH(DEPTH), .ID(ID)) dut (
    .clk(clk), .rstn(rstn),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_block(push_block),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_block(lookup_block), .empty(empty),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: queue of blocks not yet acknowledged, oldest first
  // --------------------------------------------------------------------------
  typedef struct {
    logic [27:0]  a;
    logic [127:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] wlog[$];
  logic [31:0] awlog[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_bhs    = 0;
  int last_b_cyc = -1;

  bit aw_done = 0;
  int beats   = 0;
  bit b_pend  = 0;
  int b_cnt   = 0;
  bit push_acc = 0;

  int         aw_p = 100;
  int         w_p  = 100;
  bit         w_toggle = 0;
  bit         b_rand = 0;
  int         b_delay = 0;
  logic [1:0] b_resp_val = 2'b00;

  logic        prev_awv = 0, prev_awrdy = 0, prev_wv = 0, prev_wrdy = 0, prev_wlast = 0;
  logic [31:0] prev_awaddr = 0, prev_wdata = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_lookup(input logic [31:0] la, output logic hit,
                                       output logic [127:0] blk);
    hit = 1'b0;
    blk = '0;
    foreach (q[i]) begin
      if (q[i].a == la[31:4]) begin
        hit = 1'b1;
        blk = q[i].d;   // later entries are younger and override
      end
    end
  endfunction

  task automatic model_reset();
    q.delete();
    aw_done = 0; beats = 0; b_pend = 0; b_cnt = 0;
    bvalid = 1'b0;
    prev_awv = 0; prev_wv = 0;
  endtask

  // One clock: check at the falling edge, update the model at the rising
  // edge, then drive the slave-side inputs 1 time unit later.
  task automatic cycle();
    logic         exp_hit;
    logic [127:0] exp_blk;
    logic [127:0] hb;
    bit do_push, aw_hs, w_hs, b_hs;
    @(negedge clk);
    chk("push_ready", push_ready, q.size() < DEPTH);
    chk("empty", empty, q.size() == 0);
    model_lookup(lookup_addr, exp_hit, exp_blk);
    chk("lookup_hit", lookup_hit, exp_hit);
    chk("lookup_block", lookup_block, exp_blk);
    chk("aw_phase", awvalid && (aw_done || q.size() == 0), 1'b0);
    if (awvalid && q.size() > 0) chk("awaddr", awaddr, {q[0].a, 4'h0});
    if (prev_awv && !prev_awrdy) begin
      chk("aw_hold", awvalid, 1'b1);
      chk("awaddr_hold", awaddr, prev_awaddr);
    end
    chk("w_phase", wvalid && !(aw_done && beats < 4 && q.size() > 0), 1'b0);
    if (wvalid && aw_done && beats < 4 && q.size() > 0) begin
      hb = q[0].d;
      chk("wdata", wdata, hb[32*beats +: 32]);
      chk("wlast", wlast, beats == 3);
    end
    if (prev_wv && !prev_wrdy) begin
      chk("w_hold", wvalid, 1'b1);
      chk("wdata_hold", wdata, prev_wdata);
      chk("wlast_hold", wlast, prev_wlast);
    end
    chk("bready", bready, aw_done && beats == 4);

    do_push = push_valid && (q.size() < DEPTH);
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    b_hs    = bvalid && bready;
    prev_awv = awvalid; prev_awrdy = awready; prev_awaddr = awaddr;
    prev_wv  = wvalid;  prev_wrdy  = wready;  prev_wdata  = wdata; prev_wlast = wlast;
    if (aw_hs) awlog.push_back(awaddr);
    if (w_hs)  wlog.push_back(wdata);

    @(posedge clk);
    cyc++;
    push_acc = do_push;
    if (b_hs) begin
      if (q.size() > 0) q.delete(0);
      aw_done = 0; beats = 0;
      n_bhs++; last_b_cyc = cyc;
    end
    if (w_hs && beats < 4) begin
      beats++;
      if (beats == 4) begin
        b_pend = 1;
        b_cnt  = b_rand ? int'($urandom_range(3)) : b_delay;
      end
    end
    if (aw_hs) aw_done = 1;
    if (do_push) q.push_back('{a: push_addr[31:4], d: push_block});

    #1;
    awready = ($urandom_range(99) < aw_p);
    wready  = w_toggle ? ~wready : ($urandom_range(99) < w_p);
    if (b_hs) bvalid = 1'b0;
    if (b_pend) begin
      if (b_cnt == 0) begin
        bvalid = 1'b1;
        b_pend = 0;
        bresp  = b_rand ? 2'($urandom) : b_resp_val;
        bid    = 4'($urandom);
      end else begin
        b_cnt--;
      end
    end
  endtask

  task automatic push_one(input logic [31:0] a, input logic [127:0] d, input string tag);
    push_addr  = a;
    push_block = d;
    push_valid = 1'b1;
    cycle();
    chk({tag, "_push_acc"}, push_acc, 1'b1);
    push_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(empty && q.size() == 0) && n < 300) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, empty && q.size() == 0, 1'b1);
  endtask

  logic [127:0] blk_a, blk_b;
  logic [31:0]  t1w [4];
  logic [31:0]  exp_aw[$];
  int           p, n;

  initial begin
    rstn = 1'b0; push_valid = 1'b0; push_addr = '0; push_block = '0;
    lookup_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    bid = '0; bresp = '0;

    // ---------------- reset values ----------------
    #2;
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_lookup_hit", lookup_hit, 1'b0);
    chk("rst_lookup_block", lookup_block, 128'd0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("awid", awid, 4'h1);
    chk("wid", wid, 4'h1);
    chk("awlen", awlen, 8'd3);
    chk("awsize", awsize, 3'd2);
    chk("awburst", awburst, 2'b01);
    chk("aw_misc", {awlock, awcache, awprot}, 9'd0);
    chk("wstrb", wstrb, 4'hF);
    repeat (2) cycle();
    rstn = 1'b1;

    // ---------------- single push, all ready ----------------
    aw_p = 100; w_p = 100; w_toggle = 0; b_delay = 0; b_rand = 0;
    wlog.delete();
    t1w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    lookup_addr = 32'h1C000048;
    push_one(32'h1C000040, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, "t1");
    p = cyc;
    chk("t1_awvalid_idle", awvalid, 1'b0);
    cycle();
    chk("t1_awvalid_rise", awvalid, 1'b1);
    chk("t1_awaddr", awaddr, 32'h1C000040);
    n = 0;
    while (!empty && n < 30) begin cycle(); n++; end
    chk("t1_drain_cycles", cyc - p, 7);
    chk("t1_beats", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) chk("t1_word", wlog[i], t1w[i]);

    // ---------------- fill with awready low ----------------
    aw_p = 0; awready = 1'b0;
    awlog.delete(); exp_aw.delete();
    for (int k = 0; k < 4; k++) begin
      exp_aw.push_back(32'h20000000 + 32'(k * 16));
      push_one(32'h20000000 + 32'(k * 16 + k), {4{$urandom}}, "t2");
    end
    chk("t2_full", push_ready, 1'b0);
    push_addr = 32'h20000100; push_block = {4{$urandom}}; push_valid = 1'b1;
    exp_aw.push_back(32'h20000100);
    repeat (3) begin
      cycle();
      chk("t2_stall", push_acc, 1'b0);
    end
    aw_p = 100;
    n = 0;
    push_acc = 0;
    while (!push_acc && n < 40) begin cycle(); n++; end
    chk("t2_reopen", cyc, last_b_cyc + 1);
    push_valid = 1'b0;
    drain("t2");
    chk("t2_order_len", awlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < awlog.size()) chk("t2_order", awlog[i], exp_aw[i]);

    // ---------------- duplicate address, youngest forwarded ----------------
    aw_p = 0; awready = 1'b0;
    blk_a = {4{32'hAAAA0001}};
    blk_b = {4{32'hBBBB0002}};
    push_one(32'h80001000, blk_a, "t3a");
    push_one(32'h80001004, blk_b, "t3b");
    lookup_addr = 32'h8000100C;
    cycle();
    chk("t3_hit", lookup_hit, 1'b1);
    chk("t3_block", lookup_block, blk_b);
    aw_p = 100;
    awlog.delete();
    drain("t3");
    chk("t3_miss", lookup_hit, 1'b0);
    chk("t3_two_bursts", awlog.size(), 2);

    // ---------------- wready toggling, slow error response ----------------
    w_toggle = 1; b_delay = 5; b_resp_val = 2'b10;
    wlog.delete();
    blk_a = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
    lookup_addr = 32'h40000020;
    push_one(32'h40000020, blk_a, "t4");
    drain("t4");
    chk("t4_beats", wlog.size(), 4);
    chk("t4_last_word", wlog.size() == 4 ? wlog[3] : 32'd0, 32'hD4D4D4D4);
    w_toggle = 0; b_delay = 0; b_resp_val = 2'b00;

    // ---------------- push while head drains ----------------
    push_one(32'h50000000, {4{32'h5A5A5A5A}}, "t5a");
    n = 0;
    while (!wvalid && n < 20) begin cycle(); n++; end
    chk("t5_in_w", wvalid, 1'b1);
    push_one(32'h50000010, {4{32'h6B6B6B6B}}, "t5b");
    chk("t5_count2", q.size(), 2);
    n = n_bhs; p = 0;
    while (n_bhs == n && p < 20) begin cycle(); p++; end
    chk("t5_count1", q.size(), 1);
    chk("t5_gap_idle", awvalid, 1'b0);
    cycle();
    chk("t5_second_aw", awvalid, 1'b1);
    chk("t5_second_addr", awaddr, 32'h50000010);
    drain("t5");

    // ---------------- reset during W beat 2 ----------------
    lookup_addr = 32'h60000000;
    push_one(32'h60000000, {4{$urandom}}, "t6");
    n = 0;
    while (!(wvalid && beats == 2) && n < 20) begin cycle(); n++; end
    chk("t6_at_beat2", wvalid && beats == 2, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t6_awvalid", awvalid, 1'b0);
    chk("t6_wvalid", wvalid, 1'b0);
    chk("t6_wlast", wlast, 1'b0);
    chk("t6_bready", bready, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_push_ready", push_ready, 1'b1);
    chk("t6_lookup_hit", lookup_hit, 1'b0);
    model_reset();
    repeat (2) cycle();
    rstn = 1'b1;
    repeat (3) cycle();
    chk("t6_after_release", lookup_hit, 1'b0);

    // ---------------- randomized traffic ----------------
    aw_p = 70; w_p = 70; b_rand = 1;
    for (int i = 0; i < 400; i++) begin
      push_valid  = ($urandom_range(2) == 0);
      push_addr   = {4'h9, 20'h0, 4'($urandom_range(5)), 4'($urandom)};
      push_block  = {$urandom, $urandom, $urandom, $urandom};
      lookup_addr = {4'h9, 20'h0, 4'($urandom_range(6)), 4'($urandom)};
      cycle();
    end
    push_valid = 1'b0;
    aw_p = 100; w_p = 100; b_rand = 0;
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/victim_write_buffer.md
# victim_write_buffer

Write-back buffer between the data cache's dirty-victim path and the AXI write channels. Accepts evicted 128-bit blocks in one cycle so a refill can proceed immediately, queues them in a small FIFO, and drains each entry as a 4-beat INCR AXI write burst. A combinational address lookup lets the refill path detect, and forward from, blocks still waiting in the buffer, so a refill never reads stale memory.

## Interface
- DEPTH, 4: number of block entries; power of two, ≥2.
- ID, 4'h1: constant awid/wid value.

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- push_valid  in  1  victim block offered
- push_ready  out  1  buffer can accept (not full)
- push_addr  in  32  block address; bits [3:0] ignored, treated as 0
- push_block  in  128  block data; word i = bits [32i+31:32i]
- lookup_addr  in  32  refill address (bits [31:4] compared)
- lookup_hit  out  1  a valid entry matches lookup_addr
- lookup_block  out  128  data of youngest matching entry (0 on miss)
- empty  out  1  no valid entries, drain FSM idle
- awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot  out  4,32,8,3,2,2,4,3  AXI write address; awaddr = {entry addr[31:4],4'b0}, awlen=3, awsize=2, awburst=2'b01, others 0
- awvalid  out  1; awready  in  1
- wid  out 4; wdata  out 32; wstrb  out 4 (always 4'hF); wlast  out 1; wvalid  out 1; wready  in 1
- bid  in 4; bresp  in 2; bvalid  in 1; bready  out 1

## Operation
- Storage: DEPTH entries {addr[31:4], block[127:0], valid}; head/tail pointers with extra wrap bit; full when pointers equal except wrap bit, count = tail − head.
- Push: accepted when push_valid & push_ready; written at tail, tail++. Duplicate addresses permitted; both entries kept and drained in order.
- Lookup: combinational over all valid entries, including the one currently draining; priority to youngest (closest to tail). Same-cycle push is not visible.
- Drain FSM states: IDLE, AW, W, B.
  - IDLE → AW when count ≠ 0.
  - AW: awvalid=1 with head entry; → W on awready.
  - W: wvalid=1, beat counter 0..3, wdata = head word[beat]; wlast=1 on beat 3; beat++ on wready; → B after beat 3 handshake.
  - B: bready=1; on bvalid: pop head (valid=0, head++), → IDLE. bresp/bid not checked; entry popped regardless.
- push_ready = ~full, registered-state only; a pop in the same cycle does not open a full buffer.
- Simultaneous push and pop (not full): both take effect; count unchanged.
- empty = (count==0) & (state==IDLE).
- Reset mid-burst: FSM to IDLE, all entries invalidated, AXI valids drop asynchronously; in-flight transaction abandoned (system reset resets slave too).

## Timing
- Reset values: push_ready=1, empty=1, lookup_hit=0, lookup_block=0, awvalid=0, wvalid=0, wlast=0, bready=0, wdata=0, awaddr=0; constant AXI fields at their fixed values.
- Push accepted at edge N → entry visible to lookup and count from N+1; awvalid asserted from N+1 (FSM leaves IDLE at N+1, AW at N+2 edge → awvalid high in cycle N+2). Requirement: awvalid first high in the second cycle after the push edge.
- awvalid/wvalid/wdata/wlast held stable until handshake (AXI rule); no combinational path from ready to valid.
- Minimum per-entry drain with ready always high: 1 (IDLE) + 1 (AW) + 4 (W) + 1 (B) = 7 cycles.
- lookup_hit/lookup_block purely combinational from lookup_addr and registered state.

## Test plan
- Single push addr 0x1C000040, block {0x44444444,0x33333333,0x22222222,0x11111111}, all ready high -> awaddr 0x1C000040, awlen 3, wdata 0x11111111,0x22222222,0x33333333,0x44444444 with wlast on 4th, bready, empty=1 7 cycles after awvalid-cycle start.
- Fill 4 entries with awready held low -> push_ready=0 after 4th; 5th push stalls; release awready, after first B handshake push_ready=1 next cycle; drain order = push order.
- Push 0x80001000 twice (data A then B), lookup 0x8000100C -> lookup_hit=1, lookup_block=B; after both drained lookup_hit=0.
- wready toggled 1/0 every cycle and bvalid delayed 5 cycles -> wdata stable while wvalid&~wready, exactly 4 W beats, entry popped only on bvalid, bresp=2'b10 still pops.
- Push while head draining (count 1→2→1) -> no lost entry, second burst awvalid the cycle after first B.
- Assert rstn low during W beat 2 -> all valids 0 immediately, empty=1, push_ready=1, lookup_hit=0 after release.
